// File: rtl/slowdoor_cfg_pkg.sv
// slowdoor_cfg_pkg: shared constants, state encoding and helpers
// for the serial configuration loader.
package slowdoor_cfg_pkg;

    localparam logic [7:0] SYNC_WORD = 8'hA5;
    localparam logic [7:0] EOS_ADDR  = 8'hFF;
    localparam int         ADDR_W    = 8;
    localparam int         MODE_W    = 3;
    localparam int         LUT_W     = 4;
    localparam int         PAY_W     = MODE_W + LUT_W;
    localparam int         CNT_W     = 8;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_ADDR,
        ST_PAYLOAD,
        ST_PARITY,
        ST_COMMIT,
        ST_DONE
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/slowdoor_cfg_if.sv
// slowdoor_cfg_if: serial bitstream handshake plus the
// block-write bus and status outputs of the loader.
interface slowdoor_cfg_if;
    import slowdoor_cfg_pkg::*;

    logic              cfg_valid;
    logic              cfg_bit;
    logic              cfg_ready;
    logic              blk_we;
    logic [ADDR_W-1:0] blk_addr;
    logic [MODE_W-1:0] blk_mode;
    logic [LUT_W-1:0]  blk_lut;
    logic              done;
    logic [CNT_W-1:0]  good_cnt;
    logic [CNT_W-1:0]  err_cnt;

    modport master (
        input  cfg_valid,
        input  cfg_bit,
        output cfg_ready,
        output blk_we,
        output blk_addr,
        output blk_mode,
        output blk_lut,
        output done,
        output good_cnt,
        output err_cnt
    );

    modport slave (
        output cfg_valid,
        output cfg_bit,
        input  cfg_ready,
        input  blk_we,
        input  blk_addr,
        input  blk_mode,
        input  blk_lut,
        input  done,
        input  good_cnt,
        input  err_cnt
    );

endinterface

// File: rtl/slowdoor_cfg_sync_det.sv
// slowdoor_cfg_sync_det: 8-bit shift window that flags the sync
// word on the same cycle its final bit is accepted.
module slowdoor_cfg_sync_det
    import slowdoor_cfg_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_shift,
    input  logic i_bit,
    output logic o_match
);

    logic [7:0] r_win;
    logic [7:0] w_next;

    assign w_next  = {r_win[6:0], i_bit};
    assign o_match = i_shift && (w_next == SYNC_WORD);

    // Shift accepted bits; a match or an explicit clear empties the window
    always_ff @(posedge clk) begin
        if (rst || i_clear || o_match) begin
            r_win <= '0;
        end else if (i_shift) begin
            r_win <= w_next;
        end
    end

endmodule

// File: rtl/slowdoor_cfg_loader.sv
// slowdoor_cfg_loader: frames a serial bitstream into per-block
// mode/LUT writes, with parity, range check and end-of-stream.
module slowdoor_cfg_loader
    import slowdoor_cfg_pkg::*;
#(
    parameter int NUM_BLOCKS = 16
)(
    input  logic          clk,
    input  logic          rst,
    slowdoor_cfg_if.master bus
);

    localparam logic [8:0] BLK_LIM = 9'(NUM_BLOCKS);

    state_e             r_state;
    logic [2:0]         r_cnt;
    logic [ADDR_W-1:0]  r_addr_sr;
    logic [PAY_W-1:0]   r_pay_sr;
    logic               r_par;
    logic               r_eos;
    logic               r_ready;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [MODE_W-1:0]  r_mode;
    logic [LUT_W-1:0]   r_lut;
    logic               r_done;
    logic [CNT_W-1:0]   r_good;
    logic [CNT_W-1:0]   r_err;

    logic w_take;
    logic w_hunt_shift;
    logic w_clear;
    logic w_match;
    logic w_par_ok;
    logic w_in_range;
    logic w_is_eos;

    assign w_take       = bus.cfg_valid && r_ready;
    assign w_hunt_shift = w_take && (r_state == ST_HUNT);
    assign w_clear      = (r_state == ST_COMMIT);
    assign w_par_ok     = ~(r_par ^ bus.cfg_bit);
    assign w_in_range   = ({1'b0, r_addr_sr} < BLK_LIM);
    assign w_is_eos     = (r_addr_sr == EOS_ADDR);

    slowdoor_cfg_sync_det u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_shift (w_hunt_shift),
        .i_bit   (bus.cfg_bit),
        .o_match (w_match)
    );

    // Frame FSM; the verdict and all outputs register on the parity bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_HUNT;
            r_cnt     <= '0;
            r_addr_sr <= '0;
            r_pay_sr  <= '0;
            r_par     <= 1'b0;
            r_eos     <= 1'b0;
            r_ready   <= 1'b1;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_mode    <= '0;
            r_lut     <= '0;
            r_done    <= 1'b0;
            r_good    <= '0;
            r_err     <= '0;
        end else begin
            unique case (r_state)
                ST_HUNT: begin
                    if (w_match) begin
                        r_state <= ST_ADDR;
                        r_cnt   <= '0;
                        r_par   <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    if (w_take) begin
                        r_addr_sr <= {r_addr_sr[ADDR_W-2:0], bus.cfg_bit};
                        r_par     <= r_par ^ bus.cfg_bit;
                        r_cnt     <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            r_state <= ST_PAYLOAD;
                            r_cnt   <= '0;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (w_take) begin
                        r_pay_sr <= {r_pay_sr[PAY_W-2:0], bus.cfg_bit};
                        r_par    <= r_par ^ bus.cfg_bit;
                        r_cnt    <= r_cnt + 3'd1;
                        if (r_cnt == 3'd6) begin
                            r_state <= ST_PARITY;
                            r_cnt   <= '0;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_take) begin
                        r_state <= ST_COMMIT;
                        r_ready <= 1'b0;
                        r_eos   <= 1'b0;
                        unique case (1'b1)
                            (w_par_ok && w_in_range): begin
                                r_we   <= 1'b1;
                                r_addr <= r_addr_sr;
                                r_mode <= r_pay_sr[PAY_W-1:LUT_W];
                                r_lut  <= r_pay_sr[LUT_W-1:0];
                                r_good <= sat_inc(r_good);
                            end
                            (w_par_ok && w_is_eos): begin
                                r_eos  <= 1'b1;
                                r_done <= 1'b1;
                                r_good <= sat_inc(r_good);
                            end
                            default: begin
                                r_err <= sat_inc(r_err);
                            end
                        endcase
                    end
                end
                ST_COMMIT: begin
                    r_we <= 1'b0;
                    if (r_eos) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_HUNT;
                        r_ready <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_ready <= 1'b0;
                end
                default: begin
                    r_state <= ST_HUNT;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cfg_ready = r_ready;
    assign bus.blk_we    = r_we;
    assign bus.blk_addr  = r_addr;
    assign bus.blk_mode  = r_mode;
    assign bus.blk_lut   = r_lut;
    assign bus.done      = r_done;
    assign bus.good_cnt  = r_good;
    assign bus.err_cnt   = r_err;

endmodule

// File: tb/tb_slowdoor_cfg_loader.sv
// tb_slowdoor_cfg_loader: directed frames with a write scoreboard
// and direct status checks for the configuration loader.
module tb_slowdoor_cfg_loader;

    typedef struct packed {
        logic [7:0] a;
        logic [2:0] m;
        logic [3:0] l;
    } wr_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    wr_t  sb_q[$];

    slowdoor_cfg_if bus ();

    slowdoor_cfg_loader #(.NUM_BLOCKS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (bus.blk_we === 1'b1) begin
            wr_t e;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_we actual %0h/%0h/%0h expected none",
                         bus.blk_addr, bus.blk_mode, bus.blk_lut);
            end else begin
                e = sb_q.pop_front();
                if ({bus.blk_addr, bus.blk_mode, bus.blk_lut} !== e) begin
                    errors++;
                    $display("FAIL write actual %0h/%0h/%0h expected %0h/%0h/%0h",
                             bus.blk_addr, bus.blk_mode, bus.blk_lut,
                             e.a, e.m, e.l);
                end
            end
        end
    end

    task automatic send_bit(input logic b, input int maxgap);
        int gap;
        gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        repeat (gap) begin
            @(negedge clk);
            bus.cfg_valid = 1'b0;
            bus.cfg_bit   = $urandom_range(0, 1);
        end
        @(negedge clk);
        bus.cfg_valid = 1'b1;
        bus.cfg_bit   = b;
    endtask

    task automatic send_byte(input logic [7:0] v, input int maxgap);
        for (int i = 7; i >= 0; i--) send_bit(v[i], maxgap);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [2:0] m,
                              input logic [3:0] l, input logic p,
                              input int maxgap);
        send_byte(8'hA5, maxgap);
        send_byte(a, maxgap);
        for (int i = 2; i >= 0; i--) send_bit(m[i], maxgap);
        for (int i = 3; i >= 0; i--) send_bit(l[i], maxgap);
        send_bit(p, maxgap);
    endtask

    // Check the COMMIT cycle and the cycle after it
    task automatic commit_chk(input string name, input logic we,
                              input logic rdy_after);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        chk({name, "_we"}, bus.blk_we, we);
        chk({name, "_rdy_commit"}, bus.cfg_ready, 1'b0);
        @(negedge clk);
        chk({name, "_we_low"}, bus.blk_we, 1'b0);
        chk({name, "_rdy_after"}, bus.cfg_ready, rdy_after);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_rdy"},  bus.cfg_ready, 1'b1);
        chk({name, "_we"},   bus.blk_we, 1'b0);
        chk({name, "_addr"}, bus.blk_addr, 8'h00);
        chk({name, "_mode"}, bus.blk_mode, 3'd0);
        chk({name, "_lut"},  bus.blk_lut, 4'h0);
        chk({name, "_done"}, bus.done, 1'b0);
        chk({name, "_good"}, bus.good_cnt, 8'd0);
        chk({name, "_err"},  bus.err_cnt, 8'd0);
    endtask

    initial begin
        logic [14:0] pre;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_bit   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("reset");

        // Good frame: addr 03, mode 3, lut A, six ones -> parity 0
        sb_q.push_back('{8'h03, 3'd3, 4'hA});
        send_frame(8'h03, 3'b011, 4'b1010, 1'b0, 0);
        commit_chk("good", 1'b1, 1'b1);
        chk("good_cnt1", bus.good_cnt, 8'd1);
        chk("good_err0", bus.err_cnt, 8'd0);

        // Same frame, parity flipped
        send_frame(8'h03, 3'b011, 4'b1010, 1'b1, 0);
        commit_chk("badpar", 1'b0, 1'b1);
        chk("badpar_err", bus.err_cnt, 8'd1);
        chk("hold_addr", bus.blk_addr, 8'h03);
        chk("hold_lut", bus.blk_lut, 4'hA);

        // Out of range address 0x10 with good parity (5 ones -> 1)
        send_frame(8'h10, 3'b011, 4'b1010, 1'b1, 0);
        commit_chk("range", 1'b0, 1'b1);
        chk("range_err", bus.err_cnt, 8'd2);
        chk("range_good", bus.good_cnt, 8'd1);

        // Overlapping sync: 1010 then 1010_0101 matches on bit 12
        send_bit(1'b1, 0); send_bit(1'b0, 0);
        send_bit(1'b1, 0); send_bit(1'b0, 0);
        sb_q.push_back('{8'h0F, 3'd5, 4'h6});
        send_frame(8'h0F, 3'b101, 4'b0110, 1'b0, 0);
        commit_chk("overlap", 1'b1, 1'b1);
        chk("overlap_good", bus.good_cnt, 8'd2);

        // Same good frame as the first, with random valid gaps
        sb_q.push_back('{8'h03, 3'd3, 4'hA});
        send_frame(8'h03, 3'b011, 4'b1010, 1'b0, 3);
        commit_chk("stall", 1'b1, 1'b1);
        chk("stall_good", bus.good_cnt, 8'd3);

        // Preamble 1010_0101_0100_101: sync on bit 8, addr 0100_1011
        // once one more bit is sent -> 0x4B out of range, parity 0
        pre = 15'b1010_0101_0100_101;
        for (int i = 14; i >= 0; i--) send_bit(pre[i], 2);
        send_bit(1'b1, 2);
        for (int i = 0; i < 7; i++) send_bit(1'b0, 2);
        send_bit(1'b0, 2);
        commit_chk("preamble", 1'b0, 1'b1);
        chk("preamble_err", bus.err_cnt, 8'd3);

        // Reset after 5 payload bits of a frame to block 2
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
        send_bit(1'b1, 0); send_bit(1'b1, 0);
        do_reset();
        chk_reset_outputs("midrst");
        // Addr 00, mode 7, lut F: seven ones -> parity 1
        sb_q.push_back('{8'h00, 3'd7, 4'hF});
        send_frame(8'h00, 3'b111, 4'b1111, 1'b1, 0);
        commit_chk("postrst", 1'b1, 1'b1);
        chk("postrst_good", bus.good_cnt, 8'd1);

        // End of stream: addr FF, zero payload, eight ones -> parity 0
        send_frame(8'hFF, 3'b000, 4'b0000, 1'b0, 0);
        commit_chk("eos", 1'b0, 1'b0);
        chk("eos_done", bus.done, 1'b1);
        chk("eos_good", bus.good_cnt, 8'd2);
        send_frame(8'h03, 3'b011, 4'b1010, 1'b0, 0);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("eos_stuck_rdy", bus.cfg_ready, 1'b0);
        chk("eos_stuck_done", bus.done, 1'b1);
        chk("eos_stuck_good", bus.good_cnt, 8'd2);
        chk("eos_stuck_err", bus.err_cnt, 8'd0);

        // Saturation: 256 bad frames from zero must stop at FF
        do_reset();
        chk("sat_start", bus.err_cnt, 8'd0);
        for (int n = 0; n < 256; n++) begin
            send_frame(8'h03, 3'b011, 4'b1010, 1'b1, 0);
            @(negedge clk);
            bus.cfg_valid = 1'b0;
            @(negedge clk);
        end
        chk("sat_err", bus.err_cnt, 8'hFF);
        chk("sat_good", bus.good_cnt, 8'd0);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slowdoor_cfg_loader.md
SLOWDOOR_CFG_LOADER -- requirements
Module: slowdoor_cfg_loader

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 16: number of logic blocks addressable, range 1..255.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port cfg_valid  input  1  serial bitstream bit valid.
REQ-005 SHALL have port cfg_bit  input  1  serial bitstream data, MSB-first per field.
REQ-006 SHALL have port cfg_ready  output  1  loader accepts bit; a bit transfers when cfg_valid & cfg_ready.
REQ-007 SHALL have port blk_we  output  1  one-cycle write strobe to the addressed logic block's config registers.
REQ-008 SHALL have port blk_addr  output  8  target block index.
REQ-009 SHALL have port blk_mode  output  3  routing-mode field, 3-bit mode register of the logic block.
REQ-010 SHALL have port blk_lut  output  4  LUT contents, 4-bit truth-table register of the logic block.
REQ-011 SHALL have port done  output  1  sticky: end-of-stream frame received.
REQ-012 SHALL have port good_cnt  output  8  saturating count of committed frames.
REQ-013 SHALL have port err_cnt  output  8  saturating count of rejected frames.

Function
REQ-014 SHALL implement states HUNT, ADDR, PAYLOAD, PARITY, COMMIT, DONE.
REQ-015 SHALL, in HUNT, shift accepted bits into an 8-bit window; go to ADDR on the cycle the window equals 0xA5, including overlapping matches.
REQ-016 SHALL accept exactly 8 address bits in ADDR, then 7 bits in PAYLOAD (mode[2:0] first, then lut[3:0]), then 1 bit in PARITY.
REQ-017 SHALL check even parity over the 8 address bits, 7 payload bits and the parity bit (16 bits, XOR = 0).
REQ-018 SHALL go to COMMIT after the parity bit is accepted; COMMIT lasts exactly one cycle with cfg_ready=0.
REQ-019 SHALL, in COMMIT, with parity good and addr < NUM_BLOCKS: pulse blk_we=1 for one cycle with blk_addr/blk_mode/blk_lut valid that cycle; increment good_cnt; go to HUNT.
REQ-020 SHALL, in COMMIT, with parity good and addr == 0xFF: no blk_we; set done; increment good_cnt; go to DONE.
REQ-021 SHALL, in COMMIT, with bad parity or NUM_BLOCKS <= addr < 0xFF: no blk_we; increment err_cnt; go to HUNT.
REQ-022 SHALL make blk_we rise on the cycle after the cycle in which the parity bit is accepted (1-cycle latency).
REQ-023 SHALL hold blk_addr, blk_mode and blk_lut at their last committed values when blk_we=0.
REQ-024 SHALL hold cfg_ready=1 in HUNT, ADDR, PAYLOAD and PARITY, and cfg_ready=0 in COMMIT and DONE.
REQ-025 SHALL treat cycles with cfg_valid=0 as stalls: no state, counter or shift change.
REQ-026 SHALL saturate good_cnt and err_cnt at 0xFF (no wrap).
REQ-027 SHALL stay in DONE, ignoring cfg_valid, until rst.
REQ-028 SHALL clear the HUNT window on entry to HUNT, so a new sync needs 8 fresh bits.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, enter HUNT and clear the window and bit counter; blk_we=0, blk_addr=0, blk_mode=0, blk_lut=0, done=0, good_cnt=0, err_cnt=0; cfg_ready=1 the following cycle.
REQ-030 SHALL, on rst asserted mid-frame, drop the partial frame without blk_we or any counter increment.

Structure
REQ-031 SHALL place SYNC_WORD=8'hA5, EOS_ADDR=8'hFF, field widths (ADDR_W=8, MODE_W=3, LUT_W=4) and the state enum in shared package slowdoor_cfg_pkg.
REQ-032 SHALL implement the HUNT window compare as one sub-module, slowdoor_cfg_sync_det (shift window, match flag, clear input).

Verification
REQ-033 SHALL cover a good frame: sync A5, addr 0x03, mode 3'b011, lut 4'b1010, parity 0 -> one blk_we pulse, addr=0x03, mode=3, lut=0xA, good_cnt=1.
REQ-034 SHALL cover a bad frame: the same frame with the parity bit flipped -> no blk_we, err_cnt=1, loader back in HUNT.
REQ-035 SHALL cover an out-of-range address: addr 0x10 with NUM_BLOCKS=16 and good parity -> no blk_we, err_cnt=1.
REQ-036 SHALL cover end-of-stream: addr 0xFF with good parity -> done=1, cfg_ready=0 persistent, later bits ignored until rst.
REQ-037 SHALL cover stalls and overlapping sync: random cfg_valid gaps plus preamble bits 1010_0101_0100_101 -> identical commit to the no-gap run; overlapping sync detected.
REQ-038 SHALL cover reset mid-frame: rst after 5 payload bits -> all outputs at reset values, and a following full frame commits correctly.
